// File: rtl/glb_arb_pkg.sv
// Shared types for the GLB port arbiter: requester ids, FSM states and read-return tags.
package glb_arb_pkg;

    localparam int GLB_NUM_REQ = 4;
    localparam int GLB_ID_W    = $clog2(GLB_NUM_REQ);

    typedef enum logic [GLB_ID_W-1:0] {
        REQ_WEIGHT = 2'd0,
        REQ_IFMAP  = 2'd1,
        REQ_IPSUM  = 2'd2,
        REQ_OPSUM  = 2'd3
    } req_id_e;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_e;

    typedef struct packed {
        logic                vld;
        logic [GLB_ID_W-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/glb_port_arbiter_rr_arbiter.sv
// Combinational winner pick for the GLB arbiter; round-robin from ptr by default,
// fixed priority weight>ipsum>ifmap>opsum when GLB_ARB_FIXED_PRIO_EN is defined.
import glb_arb_pkg::*;

module rr_arbiter #(
    parameter int NUM_REQ = GLB_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [GLB_ID_W-1:0] ptr,
    output logic [GLB_ID_W-1:0] winner,
    output logic                any
);

    always_comb begin
        winner = '0;
        any    = |req;
`ifdef GLB_ARB_FIXED_PRIO_EN
        if (req[REQ_WEIGHT])
            winner = REQ_WEIGHT;
        else if (req[REQ_IPSUM])
            winner = REQ_IPSUM;
        else if (req[REQ_IFMAP])
            winner = REQ_IFMAP;
        else if (req[REQ_OPSUM])
            winner = REQ_OPSUM;
`else
        // Walk from the farthest offset back to ptr so the closest requester wins last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NUM_REQ])
                winner = GLB_ID_W'((int'(ptr) + i) % NUM_REQ);
        end
`endif
    end

endmodule

// File: rtl/glb_port_arbiter.sv
// Shares the single GLB SRAM port between the loaders, one burst per grant, and
// routes read data back by tag. Optional macro: GLB_ARB_FIXED_PRIO_EN.
import glb_arb_pkg::*;

module glb_port_arbiter #(
    parameter int NUM_REQ   = GLB_NUM_REQ,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ-1:0][3:0]       req_web,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          glb_ce,
    output logic [3:0]                    glb_web,
    output logic [ADDR_W-1:0]             glb_addr,
    output logic [DATA_W-1:0]             glb_wdata,
    input  logic [DATA_W-1:0]             glb_rdata
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_e          state_q, state_d;
    logic [GLB_ID_W-1:0] gnt_id_q, gnt_id_d;
    logic [GLB_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [GLB_ID_W-1:0] winner;
    logic                any_req;
    logic                beat;
    logic                rd_beat;
    rd_tag_t             tag_pipe_q [RD_LAT];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .winner (winner),
        .any    (any_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_id_q   <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // A burst ends on last, on the beat cap, or as soon as the owner drops valid.
    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        req_ready  = '0;
        beat       = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = BURST;
                    gnt_id_d   = winner;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (winner == GLB_ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                end
            end
            BURST: begin
                req_ready[gnt_id_q] = 1'b1;
                beat                = req_valid[gnt_id_q];
                if (!req_valid[gnt_id_q] || req_last[gnt_id_q] ||
                    beat_cnt_q == CNT_W'(MAX_BURST - 1))
                    state_d = IDLE;
                else
                    beat_cnt_d = beat_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        glb_ce    = beat;
        glb_web   = beat ? req_web[gnt_id_q]   : '0;
        glb_addr  = beat ? req_addr[gnt_id_q]  : '0;
        glb_wdata = beat ? req_wdata[gnt_id_q] : '0;
        rd_beat   = beat && (req_web[gnt_id_q] == 4'h0);
    end

    // Tag pipe mirrors the GLB read latency so data returns to whoever issued it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++)
                tag_pipe_q[i] <= '0;
        end else begin
            tag_pipe_q[0] <= '{vld: rd_beat, id: gnt_id_q};
            for (int i = 1; i < RD_LAT; i++)
                tag_pipe_q[i] <= tag_pipe_q[i-1];
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (tag_pipe_q[RD_LAT-1].vld) begin
            rsp_valid[tag_pipe_q[RD_LAT-1].id] = 1'b1;
            rsp_data                           = glb_rdata;
        end
    end

endmodule

// File: tb/tb_glb_port_arbiter.sv
// Randomized self-checking bench for glb_port_arbiter against a transaction-level
// model of grant ownership and a due-cycle queue of expected read returns.
module tb_glb_port_arbiter;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       req_valid = '0;
    logic [3:0]       req_last = '0;
    logic [3:0][3:0]  req_web = '0;
    logic [3:0][31:0] req_addr = '0;
    logic [3:0][31:0] req_wdata = '0;
    logic [3:0]       req_ready;
    logic [3:0]       rsp_valid;
    logic [31:0]      rsp_data;
    logic             glb_ce;
    logic [3:0]       glb_web;
    logic [31:0]      glb_addr;
    logic [31:0]      glb_wdata;
    logic [31:0]      glb_rdata = '0;
    logic [31:0]      rd_stage1 = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    glb_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_web   (req_web),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .glb_ce    (glb_ce),
        .glb_web   (glb_web),
        .glb_addr  (glb_addr),
        .glb_wdata (glb_wdata),
        .glb_rdata (glb_rdata)
    );

    always #5 clk = ~clk;

    // GLB memory contents are a fixed scramble of the address.
    function automatic logic [31:0] glbData(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // GLB with a two-cycle read latency.
    always @(posedge clk) begin
        rd_stage1 <= (glb_ce && glb_web == 4'h0) ? glbData(glb_addr) : 32'h0;
        glb_rdata <= rd_stage1;
    end

    typedef struct {
        int          due;
        int          id;
        logic [31:0] addr;
    } exp_rsp_t;

    exp_rsp_t rsp_q[$];
    int  owner = -1;
    int  burst_beats = 0;
    int  rr_start = 0;

    bit          g_act[4];
    int          g_rem[4];
    logic [31:0] g_addr[4];
    logic [3:0]  g_web[4];
    bit          g_uselast[4];

    function automatic int pickWinner(input logic [3:0] v, input int start);
`ifdef GLB_ARB_FIXED_PRIO_EN
        int order[4];
        order = '{0, 2, 1, 3};
        for (int k = 0; k < 4; k++)
            if (v[order[k]]) return order[k];
        if (start < 0) return -1;
`else
        for (int k = 0; k < 4; k++)
            if (v[(start + k) % 4]) return (start + k) % 4;
`endif
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready"}, 64'(req_ready), 64'h0);
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'h0);
        checkOutput({tag, "_rsp_data"}, 64'(rsp_data), 64'h0);
        checkOutput({tag, "_ce"}, 64'(glb_ce), 64'h0);
        checkOutput({tag, "_web"}, 64'(glb_web), 64'h0);
        checkOutput({tag, "_addr"}, 64'(glb_addr), 64'h0);
        checkOutput({tag, "_wdata"}, 64'(glb_wdata), 64'h0);
    endtask

    task automatic resetModel();
        owner = -1;
        burst_beats = 0;
        rr_start = 0;
        rsp_q.delete();
        for (int i = 0; i < 4; i++) begin
            g_act[i] = 1'b0;
            g_rem[i] = 0;
        end
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (!g_act[i] && ($urandom % 6 == 0)) begin
                g_act[i]     = 1'b1;
                g_rem[i]     = $urandom_range(1, 20);
                g_addr[i]    = $urandom & 32'hFFFF_FFFC;
                g_uselast[i] = $urandom_range(0, 1) == 1;
                case ($urandom % 3)
                    0: g_web[i] = 4'hF;
                    1: g_web[i] = 4'(($urandom % 15) + 1);
                    default: g_web[i] = 4'h0;
                endcase
            end
            req_valid[i] = g_act[i] && ($urandom % 16 != 0);
            req_last[i]  = g_act[i] && g_uselast[i] && (g_rem[i] == 1);
            req_web[i]   = g_act[i] ? g_web[i] : 4'($urandom);
            req_addr[i]  = g_act[i] ? g_addr[i] : $urandom;
            req_wdata[i] = $urandom;
        end
    endtask

    // Compare this cycle's outputs, then advance the model; returns the accepted beat owner.
    task automatic checkCycle(output int beat_id);
        logic [3:0]  exp_ready;
        logic [3:0]  exp_rv;
        logic [31:0] exp_rd;
        bit          mbeat;
        int          p;
        exp_ready = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
        mbeat     = (owner >= 0) && req_valid[owner];
        exp_rv    = '0;
        exp_rd    = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            exp_rv = 4'b0001 << rsp_q[0].id;
            exp_rd = glbData(rsp_q[0].addr);
            void'(rsp_q.pop_front());
        end
        checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
        checkOutput("glb_ce", 64'(glb_ce), 64'(mbeat));
        checkOutput("glb_web", 64'(glb_web), mbeat ? 64'(req_web[owner]) : 64'h0);
        checkOutput("glb_addr", 64'(glb_addr), mbeat ? 64'(req_addr[owner]) : 64'h0);
        checkOutput("glb_wdata", 64'(glb_wdata), mbeat ? 64'(req_wdata[owner]) : 64'h0);
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        checkOutput("rsp_data", 64'(rsp_data), 64'(exp_rd));

        beat_id = mbeat ? owner : -1;
        if (mbeat && req_web[owner] == 4'h0)
            rsp_q.push_back('{due: cyc + 2, id: owner, addr: req_addr[owner]});
        if (owner < 0) begin
            p = pickWinner(req_valid, rr_start);
            if (p >= 0) begin
                owner       = p;
                rr_start    = (p + 1) % 4;
                burst_beats = 0;
            end
        end else if (!req_valid[owner] || req_last[owner] || burst_beats == 15) begin
            owner = -1;
        end else begin
            burst_beats++;
        end
    endtask

    initial begin
        int  beat_id;
        bit  did_reset;
        did_reset = 1'b0;
        resetModel();
        repeat (3) @(negedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            if (!did_reset && n >= 1500 && (rsp_q.size() >= 1 || n == 2500)) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                checkAllZero("midreset");
                resetModel();
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                did_reset = 1'b1;
            end
            applyStimulus();
            #1;
            checkCycle(beat_id);
            @(posedge clk);
            cyc++;
            if (beat_id >= 0) begin
                g_rem[beat_id]--;
                g_addr[beat_id] = g_addr[beat_id] + 32'd4;
                if (g_rem[beat_id] == 0)
                    g_act[beat_id] = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
